// File: rtl/stage4_pkg.sv
// Shared definitions for the stage-4 memory pipeline: instruction class bits,
// access-size encodings and the alignment / lane helpers used by 4a and 4b.
package stage4_pkg;

  localparam int WORD_W    = 32;
  localparam int INSTR_W   = 8;
  localparam int DO_LOAD   = 0;
  localparam int DO_STORE  = 1;
  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lo[0];
      default:   mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lo;
      SIZE_HALF: be = 4'b0011 << lo;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Narrow stores are replicated so whichever lane is enabled sees the right bits.
  function automatic logic [WORD_W-1:0] store_lanes(input logic [1:0] size,
                                                    input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{data[7:0]}};
      SIZE_HALF: lanes = {2{data[15:0]}};
      default:   lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [WORD_W-1:0] load_extract(input logic [1:0] size,
                                                     input logic uns,
                                                     input logic [1:0] lo,
                                                     input logic [WORD_W-1:0] rdata);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] res;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default:   res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stage4_top_data_memory.sv
// 1024 x 32-bit data RAM with a synchronous, enable-gated read register and
// per-byte write enables. Contents are deliberately not reset.
module data_memory
  import stage4_pkg::*;
(
  input  logic              clock,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [MEM_DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stage4_top.sv
// Memory stage split into 4a (issue access) and 4b (align/extend), feeding the
// registered writeback (s5) boundary. Stall freezes everything; reset clears valids.
module stage4_top
  import stage4_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               valid,
  input  logic [INSTR_W-1:0] instr_type,
  input  logic [1:0]         mem_size,
  input  logic               mem_unsigned,
  input  logic [WORD_W-1:0]  eval,
  input  logic [WORD_W-1:0]  s4a_rs2_val,
  input  logic [4:0]         rd_in,
  input  logic               reg_write_in,
  output logic [WORD_W-1:0]  s5_result,
  output logic [4:0]         s5_rd,
  output logic               s5_reg_write,
  output logic               s5_valid,
  output logic [WORD_W-1:0]  s4b_bypass_value,
  output logic               s4b_is_load,
  output logic               misalign_fault
);

  logic              w_is_load;
  logic              w_is_store;
  logic              w_mis;
  logic              w_we;
  logic [3:0]        w_be;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;
  logic              w_unused;

  assign w_is_load  = instr_type[DO_LOAD];
  assign w_is_store = instr_type[DO_STORE];
  assign w_mis      = (w_is_load | w_is_store) & is_misaligned(mem_size, eval[1:0]);
  assign w_be       = byte_enables(mem_size, eval[1:0]);
  assign w_wdata    = store_lanes(mem_size, s4a_rs2_val);
  assign w_unused   = ^instr_type[INSTR_W-1:2];

  // Reset gates the write so a store caught in 4a during reset is dropped.
  assign w_we = valid & w_is_store & ~w_mis & ~stall & ~reset;

  data_memory u_mem (
    .clock   (clock),
    .i_re    (~stall),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (eval[11:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  logic              r_b_valid;
  logic              r_b_load;
  logic              r_b_mis;
  logic [1:0]        r_b_size;
  logic              r_b_unsigned;
  logic [WORD_W-1:0] r_b_eval;
  logic [4:0]        r_b_rd;
  logic              r_b_rw;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_b_valid    <= 1'b0;
      r_b_load     <= 1'b0;
      r_b_mis      <= 1'b0;
      r_b_size     <= 2'd0;
      r_b_unsigned <= 1'b0;
      r_b_eval     <= '0;
      r_b_rd       <= 5'd0;
      r_b_rw       <= 1'b0;
    end else if (!stall) begin
      r_b_valid    <= valid;
      r_b_load     <= w_is_load;
      r_b_mis      <= w_mis;
      r_b_size     <= mem_size;
      r_b_unsigned <= mem_unsigned;
      r_b_eval     <= eval;
      r_b_rd       <= rd_in;
      r_b_rw       <= reg_write_in;
    end
  end

  logic              w_b_ld;
  logic [WORD_W-1:0] w_b_result;

  assign w_b_ld     = r_b_valid & r_b_load;
  assign w_b_result = !w_b_ld ? r_b_eval :
                      r_b_mis ? '0 :
                      load_extract(r_b_size, r_b_unsigned, r_b_eval[1:0], w_rdata);

  logic [WORD_W-1:0] r_s5_result;
  logic [4:0]        r_s5_rd;
  logic              r_s5_rw;
  logic              r_s5_valid;
  logic              r_fault;

  // A misaligned load is still a live slot but must never update the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s5_result <= '0;
      r_s5_rd     <= 5'd0;
      r_s5_rw     <= 1'b0;
      r_s5_valid  <= 1'b0;
      r_fault     <= 1'b0;
    end else if (!stall) begin
      r_s5_result <= w_b_result;
      r_s5_rd     <= r_b_rd;
      r_s5_rw     <= r_b_valid & r_b_rw & ~(r_b_load & r_b_mis);
      r_s5_valid  <= r_b_valid;
      r_fault     <= r_b_valid & r_b_mis;
    end
  end

  assign s5_result        = r_s5_result;
  assign s5_rd            = r_s5_rd;
  assign s5_reg_write     = r_s5_rw;
  assign s5_valid         = r_s5_valid;
  assign misalign_fault   = r_fault;
  assign s4b_bypass_value = r_b_eval;
  assign s4b_is_load      = w_b_ld;

endmodule

// File: doc/stage4_top.md
STAGE4_TOP -- requirements
Module: stage4_top

Interface
REQ-001 clock  in  1  single system clock; all state updates on posedge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 stall  in  1  pipeline freeze; all stage-4 state holds while high.
REQ-004 valid  in  1  stage-4a slot holds a live instruction.
REQ-005 instr_type  in  `range_instrs  decoded class vector; uses `do_load, `do_store.
REQ-006 mem_size  in  2  access width: 0 byte, 1 half, 2 word; 3 reserved, treated as word.
REQ-007 mem_unsigned  in  1  load zero-extends when high, sign-extends when low.
REQ-008 eval  in  word  execute-stage result, registered; effective address or ALU result.
REQ-009 s4a_rs2_val  in  word  store data, registered in execute.
REQ-010 rd_in  in  5  destination register; reg_write_in  in  1  instruction writes rd.
REQ-011 s5_result  out  word  load data or passed-through eval.
REQ-012 s5_rd  out  5; s5_reg_write  out  1; s5_valid  out  1  writeback-stage controls.
REQ-013 s4b_bypass_value  out  word  stage-4b non-load result, for forwarding.
REQ-014 s4b_is_load  out  1  stage-4b holds a valid load; decode uses it to stall dependants.
REQ-015 misalign_fault  out  1  one-cycle pulse for a misaligned access leaving 4b.

Function
REQ-016 Two internal sub-stages: 4a issues the memory access; 4b aligns and extends data; 4b-to-s5 register boundary.
REQ-017 Non-load result latency: eval presented in cycle N appears on s5_result in cycle N+2.
REQ-018 Load latency: address in cycle N; aligned data on s5_result in cycle N+2.
REQ-019 Data memory: 1024 x 32-bit words, indexed by eval[11:2]; eval[31:12] ignored, so addresses wrap modulo 4 KiB.
REQ-020 Memory read is synchronous, issued in 4a; the read register updates only when stall is low.
REQ-021 Store writes at the posedge ending cycle N, only when valid, `do_store set, stall low, and the access is aligned.
REQ-022 Byte enables: byte 1<<eval[1:0]; half 3<<eval[1:0]; word 4'b1111; store data replicated across lanes.
REQ-023 Misaligned: half with eval[0]=1; word with eval[1:0]!=0.
REQ-024 Misaligned store writes nothing. Misaligned load returns 0 with s5_reg_write forced low. Both raise misalign_fault for one cycle as the instruction leaves 4b.
REQ-025 Load extraction: select lane by the registered eval[1:0], then sign- or zero-extend per mem_unsigned.
REQ-026 A load in cycle N+1 at the address stored in cycle N returns the new data; no extra forwarding needed.
REQ-027 Invalid slots (valid=0) propagate as bubbles: s5_valid=0, s5_reg_write=0, no store, no fault.
REQ-028 stall high: 4a/4b/s5 registers, memory read register and misalign_fault all hold; no memory write.
REQ-029 s4b_is_load = 4b valid & `do_load; s4b_bypass_value = registered eval in 4b.

Reset
REQ-030 On reset, clear all valid bits, s5_reg_write, s5_rd, s5_result, misalign_fault and s4b_is_load; s4b_bypass_value resets to 0.
REQ-031 Reset overrides stall; an in-flight store in 4a during the reset cycle is not written.
REQ-032 Memory contents are not reset.

Structure
REQ-033 `do_load/`do_store indices and the mem_size encodings live in the common definitions header, beside `range_instrs and word.
REQ-034 One sub-module, data_memory: synchronous read, byte-enabled write, read-enable input; stage4_top holds the pipeline registers and alignment logic.

Verification
REQ-035 Store word 0xDEADBEEF to 0x100, then load word 0x100 next cycle -> s5_result=0xDEADBEEF two cycles after the load, s5_reg_write=1.
REQ-036 Store byte 0x80 to 0x203, then load byte 0x203 signed -> 0xFFFFFF80; unsigned -> 0x00000080; other bytes of word 0x200 unchanged.
REQ-037 Load half at 0x101 -> misalign_fault pulses one cycle, s5_result=0, s5_reg_write=0; store word to 0x102 -> memory unchanged, fault pulses.
REQ-038 Non-load eval=0x12345678, rd=5 -> s4b_bypass_value=0x12345678 next cycle; s5_result=0x12345678, s5_rd=5 the cycle after.
REQ-039 Store pending in 4a with stall high for 3 cycles -> no write and outputs frozen; write happens on the first unstalled edge.
REQ-040 Store to 0x1004 -> reads back at 0x0004 (wrap); reset asserted mid-load -> s5_valid=0 and no fault next cycle.
